// File: rtl/pong_game_ctrl.sv
// Game-flow controller for pong: menu/serve/run/pause/finish sequencing, ball and paddle
// step enables, speed level and two-digit BCD score.
module pong_game_ctrl #(
  parameter int unsigned DIV0         = 8,
  parameter int unsigned DIV1         = 6,
  parameter int unsigned DIV2         = 4,
  parameter int unsigned DIV3         = 2,
  parameter int unsigned SERVE_TICKS  = 30,
  parameter int unsigned FLASH_TICKS  = 8,
  parameter int unsigned SPEEDUP_HITS = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_tick_i,
  input  logic       key1_i,
  input  logic       key2_i,
  input  logic       key3_i,
  input  logic       hit_i,
  input  logic       miss_i,
  output logic [2:0] state_o,
  output logic       game_rst_o,
  output logic       run_en_o,
  output logic       ball_step_o,
  output logic       player_step_o,
  output logic [1:0] difficulty_o,
  output logic [1:0] level_o,
  output logic [3:0] score_tens_o,
  output logic [3:0] score_ones_o,
  output logic       blank_o
);

  typedef enum logic [2:0] {
    StMenu     = 3'd0,
    StServe    = 3'd1,
    StRunning  = 3'd2,
    StPaused   = 3'd3,
    StFinished = 3'd4
  } state_e;

  localparam logic [15:0] ServeLast = 16'(SERVE_TICKS - 1);
  localparam logic [15:0] FlashLast = 16'(FLASH_TICKS - 1);
  localparam logic [7:0]  HitsLast  = 8'(SPEEDUP_HITS - 1);

  function automatic logic [15:0] div_last_of(input logic [1:0] lvl);
    logic [15:0] r;
    unique case (lvl)
      2'd0: r = 16'(DIV0 - 1);
      2'd1: r = 16'(DIV1 - 1);
      2'd2: r = 16'(DIV2 - 1);
      2'd3: r = 16'(DIV3 - 1);
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  key_q;
  logic [1:0]  difficulty_q, difficulty_d, level_q, level_d;
  logic [3:0]  tens_q, tens_d, ones_q, ones_d;
  logic [7:0]  hit_cnt_q, hit_cnt_d;
  logic [15:0] div_cnt_q, div_cnt_d, div_last_q, div_last_d;
  logic [15:0] serve_cnt_q, serve_cnt_d, flash_cnt_q, flash_cnt_d;
  logic        blank_q, blank_d, game_rst_q, game_rst_d, run_en_q, run_en_d;
  logic        ball_step_q, ball_step_d, player_step_q, player_step_d;
  logic        edge1, edge2, edge3;

  assign edge1 = key1_i & ~key_q[0];
  assign edge2 = key2_i & ~key_q[1];
  assign edge3 = key3_i & ~key_q[2];

  always_comb begin
    state_d       = state_q;
    difficulty_d  = difficulty_q;
    level_d       = level_q;
    tens_d        = tens_q;
    ones_d        = ones_q;
    hit_cnt_d     = hit_cnt_q;
    div_cnt_d     = div_cnt_q;
    div_last_d    = div_last_q;
    serve_cnt_d   = serve_cnt_q;
    flash_cnt_d   = flash_cnt_q;
    blank_d       = blank_q;
    ball_step_d   = 1'b0;
    player_step_d = 1'b0;

    unique case (state_q)
      StMenu: begin
        if (edge3) begin
          state_d     = StServe;
          tens_d      = 4'd0;
          ones_d      = 4'd0;
          level_d     = difficulty_q;
          hit_cnt_d   = 8'd0;
          div_cnt_d   = 16'd0;
          div_last_d  = div_last_of(difficulty_q);
          serve_cnt_d = 16'd0;
        end else if (edge1) begin
          difficulty_d = difficulty_q + 2'd1;
        end else if (edge2) begin
          difficulty_d = difficulty_q - 2'd1;
        end
      end
      StServe: begin
        if (frame_tick_i) begin
          if (serve_cnt_q == ServeLast) state_d = StRunning;
          else serve_cnt_d = serve_cnt_q + 16'd1;
        end
      end
      StRunning: begin
        player_step_d = frame_tick_i;
        if (miss_i) begin
          state_d = StFinished;
        end else begin
          if (hit_i) begin
            if (!(tens_q == 4'd9 && ones_q == 4'd9)) begin
              if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
              end else begin
                ones_d = ones_q + 4'd1;
              end
            end
            if (hit_cnt_q == HitsLast) begin
              hit_cnt_d = 8'd0;
              if (level_q != 2'd3) level_d = level_q + 2'd1;
            end else begin
              hit_cnt_d = hit_cnt_q + 8'd1;
            end
          end
          if (edge1) state_d = StPaused;
        end
        // The divisor is latched at each wrap so a level change never cuts a period short.
        if (frame_tick_i) begin
          if (div_cnt_q == div_last_q) begin
            ball_step_d = 1'b1;
            div_cnt_d   = 16'd0;
            div_last_d  = div_last_of(level_d);
          end else begin
            div_cnt_d = div_cnt_q + 16'd1;
          end
        end
      end
      StPaused: begin
        if (edge3) state_d = StFinished;
        else if (edge2) state_d = StRunning;
      end
      StFinished: begin
        if (edge1) begin
          state_d = StMenu;
        end else if (frame_tick_i) begin
          if (flash_cnt_q == FlashLast) begin
            flash_cnt_d = 16'd0;
            blank_d     = ~blank_q;
          end else begin
            flash_cnt_d = flash_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = StMenu;
    endcase

    if (state_d == StFinished && state_q != StFinished) begin
      blank_d     = 1'b1;
      flash_cnt_d = 16'd0;
    end else if (state_d == StMenu) begin
      blank_d = 1'b1;
    end else if (state_d != StFinished) begin
      blank_d = 1'b0;
    end

    game_rst_d = (state_q == StMenu) && (state_d == StServe);
    run_en_d   = (state_d == StRunning);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StMenu;
      key_q         <= 3'b111;
      difficulty_q  <= 2'd0;
      level_q       <= 2'd0;
      tens_q        <= 4'd0;
      ones_q        <= 4'd0;
      hit_cnt_q     <= 8'd0;
      div_cnt_q     <= 16'd0;
      div_last_q    <= 16'd0;
      serve_cnt_q   <= 16'd0;
      flash_cnt_q   <= 16'd0;
      blank_q       <= 1'b1;
      game_rst_q    <= 1'b0;
      run_en_q      <= 1'b0;
      ball_step_q   <= 1'b0;
      player_step_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_q         <= {key3_i, key2_i, key1_i};
      difficulty_q  <= difficulty_d;
      level_q       <= level_d;
      tens_q        <= tens_d;
      ones_q        <= ones_d;
      hit_cnt_q     <= hit_cnt_d;
      div_cnt_q     <= div_cnt_d;
      div_last_q    <= div_last_d;
      serve_cnt_q   <= serve_cnt_d;
      flash_cnt_q   <= flash_cnt_d;
      blank_q       <= blank_d;
      game_rst_q    <= game_rst_d;
      run_en_q      <= run_en_d;
      ball_step_q   <= ball_step_d;
      player_step_q <= player_step_d;
    end
  end

  assign state_o       = state_q;
  assign game_rst_o    = game_rst_q;
  assign run_en_o      = run_en_q;
  assign ball_step_o   = ball_step_q;
  assign player_step_o = player_step_q;
  assign difficulty_o  = difficulty_q;
  assign level_o       = level_q;
  assign score_tens_o  = tens_q;
  assign score_ones_o  = ones_q;
  assign blank_o       = blank_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed scenarios plus random stimulus, every cycle compared
// against a behavioural model of the game rules.
module tb_pong_game_ctrl;

  localparam int Serve   = 30;
  localparam int Flash   = 8;
  localparam int Speedup = 5;
  int divs[4] = '{8, 6, 4, 2};

  logic clk = 1'b0;
  logic rst, fk, k1, k2, k3, h, m;
  logic [2:0] state;
  logic game_rst, run_en, ball_step, player_step, blank;
  logic [1:0] difficulty, level;
  logic [3:0] tens, ones;

  int n_checks = 0;
  int n_fail   = 0;
  int ball_cnt = 0;

  // Model of the game: plain integers for phase, score and tick counts.
  int m_state, m_diff, m_level, m_score, m_hits, m_since, m_period, m_serve, m_flash;
  bit m_blank, m_game_rst, m_run_en, m_ball, m_player;
  bit kp1, kp2, kp3;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .frame_tick_i (fk),
    .key1_i       (k1),
    .key2_i       (k2),
    .key3_i       (k3),
    .hit_i        (h),
    .miss_i       (m),
    .state_o      (state),
    .game_rst_o   (game_rst),
    .run_en_o     (run_en),
    .ball_step_o  (ball_step),
    .player_step_o(player_step),
    .difficulty_o (difficulty),
    .level_o      (level),
    .score_tens_o (tens),
    .score_ones_o (ones),
    .blank_o      (blank)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_diff = 0; m_level = 0; m_score = 0; m_hits = 0;
    m_since = 0; m_period = divs[0]; m_serve = 0; m_flash = 0;
    m_blank = 1; m_game_rst = 0; m_run_en = 0; m_ball = 0; m_player = 0;
    kp1 = 1; kp2 = 1; kp3 = 1;
  endtask

  task automatic model_step();
    bit e1, e2, e3;
    if (rst) begin
      model_reset();
      return;
    end
    e1 = k1 && !kp1; e2 = k2 && !kp2; e3 = k3 && !kp3;
    kp1 = k1; kp2 = k2; kp3 = k3;
    m_game_rst = 0; m_ball = 0; m_player = 0;
    case (m_state)
      0: begin
        if (e3) begin
          m_state = 1; m_game_rst = 1; m_score = 0; m_level = m_diff; m_hits = 0;
          m_since = 0; m_period = divs[m_diff]; m_serve = 0;
        end else if (e1) m_diff = (m_diff + 1) % 4;
        else if (e2) m_diff = (m_diff + 3) % 4;
      end
      1: if (fk) begin
        m_serve++;
        if (m_serve == Serve) m_state = 2;
      end
      2: begin
        m_player = fk;
        if (m) begin
          m_state = 4; m_blank = 1; m_flash = 0;
        end else begin
          if (h) begin
            if (m_score < 99) m_score++;
            m_hits++;
            if (m_hits == Speedup) begin
              m_hits = 0;
              if (m_level < 3) m_level++;
            end
          end
          if (e1) m_state = 3;
        end
        if (fk) begin
          m_since++;
          if (m_since == m_period) begin
            m_ball = 1; m_since = 0; m_period = divs[m_level];
          end
        end
      end
      3: begin
        if (e3) begin
          m_state = 4; m_blank = 1; m_flash = 0;
        end else if (e2) m_state = 2;
      end
      default: begin
        if (e1) m_state = 0;
        else if (fk) begin
          m_flash++;
          if (m_flash == Flash) begin
            m_flash = 0; m_blank = !m_blank;
          end
        end
      end
    endcase
    if (m_state == 0) m_blank = 1;
    else if (m_state != 4) m_blank = 0;
    m_run_en = (m_state == 2);
  endtask

  task automatic compare_all();
    check("state", state, m_state);
    check("game_rst", game_rst, m_game_rst);
    check("run_en", run_en, m_run_en);
    check("ball_step", ball_step, m_ball);
    check("player_step", player_step, m_player);
    check("difficulty", difficulty, m_diff);
    check("level", level, m_level);
    check("score_tens", tens, m_score / 10);
    check("score_ones", ones, m_score % 10);
    check("blank", blank, m_blank);
  endtask

  // One clock: inputs are already driven; model advances on the edge, compare on the negedge.
  task automatic tick();
    if (rst) model_reset();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (ball_step === 1'b1) ball_cnt++;
    fk = 0; h = 0; m = 0;
  endtask

  task automatic press(input int k);
    if (k == 1) k1 = 1; else if (k == 2) k2 = 1; else k3 = 1;
    tick();
    k1 = 0; k2 = 0; k3 = 0;
    tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      fk = 1; tick();
      tick();
    end
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      h = 1; tick();
    end
  endtask

  task automatic start_game();
    press(3);
    frames(Serve);
  endtask

  initial begin
    rst = 1; fk = 0; k1 = 0; k2 = 0; k3 = 0; h = 0; m = 0;
    model_reset();
    tick();
    tick();
    rst = 0;
    tick();
    check("reset_state", state, 0);
    check("reset_blank", blank, 1);

    // Difficulty selection in the menu.
    press(1); press(1); press(1);
    check("diff_up3", difficulty, 3);
    press(2);
    check("diff_down", difficulty, 2);
    check("menu_state", state, 0);

    // Start at difficulty 2: one-cycle game_rst, then serve, then running at period 4.
    k3 = 1; tick();
    check("game_rst_pulse", game_rst, 1);
    check("serve_state", state, 1);
    k3 = 0; tick();
    check("game_rst_low", game_rst, 0);
    frames(Serve);
    check("running_state", state, 2);
    check("run_en_high", run_en, 1);
    ball_cnt = 0;
    frames(16);
    check("steps_div4", ball_cnt, 4);

    // Back to menu, difficulty 2 -> 3 -> 0, then 12 hits.
    m = 1; tick();
    press(1);
    press(1); press(1);
    check("diff_wrap0", difficulty, 0);
    start_game();
    hits(12);
    check("score12_tens", tens, 1);
    check("score12_ones", ones, 2);
    check("level_after12", level, 2);
    frames(20);

    // Pause mid-divide at count 3 of 8.
    m = 1; tick();
    press(1);
    start_game();
    frames(3);
    press(1);
    check("paused_state", state, 3);
    ball_cnt = 0;
    frames(10);
    check("no_step_paused", ball_cnt, 0);
    press(2);
    check("resumed_state", state, 2);
    frames(4);
    check("no_step_yet", ball_cnt, 0);
    frames(1);
    check("step_after5", ball_cnt, 1);

    // Hit with miss in the same cycle: finish, score held, blank flashes.
    hits(3);
    h = 1; m = 1; tick();
    check("finished_state", state, 4);
    check("score_held_ones", ones, 3);
    check("blank_entry", blank, 1);
    frames(Flash);
    check("blank_toggle1", blank, 0);
    frames(Flash);
    check("blank_toggle2", blank, 1);
    press(1);
    check("menu_again", state, 0);
    check("menu_blank", blank, 1);
    check("menu_score_kept", ones, 3);

    // Score saturation, then reset mid-game.
    start_game();
    hits(99);
    check("score99_tens", tens, 9);
    check("score99_ones", ones, 9);
    hits(1);
    check("score_sat_tens", tens, 9);
    check("score_sat_ones", ones, 9);
    rst = 1; tick();
    rst = 0; tick();
    check("rst_state", state, 0);
    check("rst_score", tens * 10 + ones, 0);
    check("rst_level", level, 0);
    check("rst_blank", blank, 1);

    // Random play.
    for (int i = 0; i < 4000; i++) begin
      fk = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) k1 = !k1;
      if ($urandom_range(0, 7) == 0) k2 = !k2;
      if ($urandom_range(0, 9) == 0) k3 = !k3;
      h = ($urandom_range(0, 5) == 0);
      m = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 699) == 0);
      tick();
      rst = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
